keyb_8042_port: RTL
===================

// Module: keyb_8042_port
// PURPOSE
//  CPU-side half of the 8042-compatible keyboard controller. Sits directly downstream of the PS/2
//  scancode receiver: takes each translated scancode using its intr/inta handshake and buffers it
//  in a FIFO. Exposes data (0x60) and status/command (0x64) ports to the Wishbone bus. Drives
//  IRQ1 to the PIC.
// PARAMETERS
//  FIFO_AW   4   FIFO address width; depth = 2**FIFO_AW entries (16)
// PORTS
//  wb_clk_i    in   1  system clock; all logic on rising edge
//  wb_rst_ni   in   1  reset, asynchronous assert, active-low
//  kb_dat_i    in   8  scancode from PS/2 receiver; valid whenever kb_irq_i=1
//  kb_irq_i    in   1  receiver intr: byte pending
//  kb_inta_o   out  1  receiver inta: one-cycle accept pulse
//  wb_cyc_i    in   1  Wishbone cycle
//  wb_stb_i    in   1  Wishbone strobe
//  wb_we_i     in   1  1=write
//  wb_adr_i    in   1  0=data port 0x60, 1=status/command port 0x64 (decoded externally)
//  wb_dat_i    in   8  write data
//  wb_dat_o    out  8  read data
//  wb_ack_o    out  1  Wishbone ack
//  wb_tgc_o    out  1  IRQ1 to PIC
// BEHAVIOUR
//  Reset (wb_rst_ni=0, async):
//   - Outputs: kb_inta_o=0, wb_ack_o=0, wb_tgc_o=0, wb_dat_o=8'h00.
//   - State: FIFO empty, rd/wr pointers=0, count=0, hold=8'h00, ovf=0, kbd_en=1.
//  Upstream capture:
//   - take = kb_irq_i & ~kb_inta_o & kbd_en.
//   - kb_inta_o <= take, giving a one-cycle pulse. The receiver drops kb_irq_i one cycle after
//     the pulse, so each byte is taken exactly once.
//   - On take: push kb_dat_i if not full.
//   - If full and no pop in the same cycle: drop the byte, set ovf=1; inta is still pulsed so the
//     receiver never stalls.
//   - kbd_en=0: no take; the receiver holds its byte until re-enabled.
//  Bus cycle:
//   - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o, a single-cycle ack one clock after strobe.
//   - Reads and side effects commit on the edge that raises ack; wb_dat_o is registered on the
//     same edge.
//  Read data port:
//   - Non-empty: wb_dat_o=head, pop, and hold<=head.
//   - Empty: wb_dat_o=hold and no pop, so a repeated read returns the last byte.
//  Read status port: wb_dat_o={ovf,1'b0,1'b0,kbd_en,1'b0,1'b1,1'b0,obf}.
//   - obf = count!=0; bit2 = system flag = 1; bit1 = IBF, always 0.
//   - ovf is cleared by this read; a set in the same cycle wins.
//  Write status port (command):
//   - 8'hAD: kbd_en=0.
//   - 8'hAE: kbd_en=1.
//   - 8'hA5: flush; pointers/count=0, ovf=0, hold unchanged.
//   - Other values: acked, no effect.
//  Write data port: acked, ignored.
//  Simultaneous push and pop:
//   - Both are performed; count unchanged.
//   - Full + pop + push: the push is accepted, no ovf.
//   - Empty + pop + push: the read returns hold and the pushed byte stays queued.
//   - Flush in the same cycle as a push: flush wins, the byte is dropped, and ovf is not set.
//  Pointers and count:
//   - Pointers are FIFO_AW bits and wrap modulo depth.
//   - count is FIFO_AW+1 bits, range 0..2**FIFO_AW.
//  IRQ:
//   - wb_tgc_o <= obf_next & ~pop, so the line is high while data is queued.
//   - After any data-port pop it drops for exactly one cycle, then re-rises if bytes remain, so
//     the edge-triggered PIC sees a new edge per byte.
// TESTING
//  - Single byte: inject 8'h1E with kb_irq_i held until inta -> exactly one inta pulse, status
//    reads 8'h15 with IRQ high; data read returns 8'h1E, IRQ low, status then reads 8'h14.
//  - Fill: push 16 bytes 8'h01..8'h10 -> status bit0=1, bit7=0. A 17th byte 8'h99 is acked
//    upstream and dropped: status reads 8'h95, then 8'h15 on the next read. 16 data reads
//    return 8'h01..8'h10 in order, with an IRQ low pulse after each pop.
//  - Empty re-read: after the last pop, two further data reads both return 8'h10 and IRQ stays 0.
//  - Disable: write 8'hAD, drive kb_irq_i=1 with 8'h2A -> no inta and FIFO stays empty. Write
//    8'hAE -> inta pulses, data read returns 8'h2A.
//  - Wrap and simultaneity: run 40 push/pop cycles with push and pop in the same cycle at full
//    and at empty -> data order preserved, count correct, ovf never set. Flush (8'hA5) with 5
//    queued -> status bit0=0, IRQ=0.
//  - Async reset mid-transfer: assert wb_rst_ni while inta is high and 3 bytes are queued ->
//    all outputs reach reset values immediately; after release, status reads 8'h14.

Source files
------------

// File: rtl/keyb_8042_port_if.sv
// Signal bundle between the 8042 CPU-side port, the PS/2 scancode receiver and the Wishbone bus.
// Names keep the _i/_o direction suffixes as seen from the controller (slave modport).
interface keyb_8042_port_if;
  logic [7:0] kb_dat_i;
  logic       kb_irq_i;
  logic       kb_inta_o;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       wb_tgc_o;

  modport slave (
    input  kb_dat_i, kb_irq_i,
    output kb_inta_o,
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_tgc_o
  );

  modport master (
    output kb_dat_i, kb_irq_i,
    input  kb_inta_o,
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_tgc_o
  );
endinterface

// File: rtl/keyb_8042_port.sv
// CPU-side half of an 8042-compatible keyboard controller: scancode FIFO, data/status ports
// on Wishbone, and the IRQ1 line to the PIC.
module keyb_8042_port #(
  parameter int FIFO_AW = 4
) (
  input logic               wb_clk_i,
  input logic               wb_rst_ni,
  keyb_8042_port_if.slave   bus
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  localparam logic [7:0] CMD_DISABLE = 8'hAD;
  localparam logic [7:0] CMD_ENABLE  = 8'hAE;
  localparam logic [7:0] CMD_FLUSH   = 8'hA5;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         hold_q, hold_d;
  logic               ovf_q, ovf_d;
  logic               kbd_en_q, kbd_en_d;
  logic               inta_q, inta_d;
  logic               ack_q, ack_d;
  logic [7:0]         dat_q, dat_d;
  logic               tgc_q, tgc_d;

  logic       take, bus_req, rd_data, rd_stat, wr_cmd, flush;
  logic       empty, full, pop, push, ovf_set;
  logic [7:0] head, status;

  // Handshakes: upstream, a byte is offered while kb_irq_i=1 and accepted by the one-cycle
  // kb_inta_o pulse; on the bus, a request is cyc&stb and completes with a one-cycle ack,
  // where every read and side effect commits on the same edge that raises ack.
  always_comb begin
    take    = bus.kb_irq_i & ~inta_q & kbd_en_q;
    bus_req = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    rd_data = bus_req & ~bus.wb_we_i & ~bus.wb_adr_i;
    rd_stat = bus_req & ~bus.wb_we_i &  bus.wb_adr_i;
    wr_cmd  = bus_req &  bus.wb_we_i &  bus.wb_adr_i;
    flush   = wr_cmd & (bus.wb_dat_i == CMD_FLUSH);

    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    head    = mem_q[rd_ptr_q];
    status  = {ovf_q, 2'b00, kbd_en_q, 1'b0, 1'b1, 1'b0, ~empty};

    // A pop in the same cycle frees the slot a full FIFO needs; a flush discards the byte.
    pop     = rd_data & ~empty;
    push    = take & (~full | pop) & ~flush;
    ovf_set = take & full & ~pop & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    ovf_d    = ovf_q;
    kbd_en_d = kbd_en_q;
    dat_d    = dat_q;
    inta_d   = take;
    ack_d    = bus_req;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Flush clears, an overflow set beats the status-read clear.
    if (flush)        ovf_d = 1'b0;
    else if (ovf_set) ovf_d = 1'b1;
    else if (rd_stat) ovf_d = 1'b0;

    if (wr_cmd && bus.wb_dat_i == CMD_DISABLE) kbd_en_d = 1'b0;
    if (wr_cmd && bus.wb_dat_i == CMD_ENABLE)  kbd_en_d = 1'b1;

    if (pop) hold_d = head;
    if (rd_data) dat_d = empty ? hold_q : head;
    if (rd_stat) dat_d = status;

    // Forcing a low cycle after each pop gives the edge-triggered PIC one edge per byte.
    tgc_d = (count_d != '0) & ~pop;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= 8'h00;
      ovf_q    <= 1'b0;
      kbd_en_q <= 1'b1;
      inta_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      tgc_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
      kbd_en_q <= kbd_en_d;
      inta_q   <= inta_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      tgc_q    <= tgc_d;
    end
  end

  // Storage carries no reset; entries are only read once the count says they were written.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.kb_dat_i;
  end

  assign bus.kb_inta_o = inta_q;
  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.wb_tgc_o  = tgc_q;

endmodule
